// File: rtl/loop_sequencer_pkg.sv
// Shared BeeF core definitions: op codes, PC source select, and the states and
// fault codes of the loop sequencer.
package loop_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_INC, OP_DEC, OP_RIGHT, OP_LEFT, OP_OUT, OP_IN, OP_CBF, OP_CBB
  } op_code_t;

  typedef enum logic {
    PC_INCREMENTED, PC_LOOP_TARGET
  } pc_src_t;

  typedef enum logic [1:0] {
    SEQ_RUN, SEQ_SKIP, SEQ_FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    FLT_NONE, FLT_OVERFLOW, FLT_UNDERFLOW, FLT_NEST
  } fault_t;

endpackage

// File: rtl/loop_stack.sv
// LIFO of loop start addresses. The top entry lives in its own register so the
// loop target is available with no memory read latency.
module loop_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [ADDR_W-1:0]          i_push_data,
  output logic [ADDR_W-1:0]          o_top,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_top;
  logic [CW-1:0]     r_count;
  logic              w_full, w_empty, w_do_push, w_do_pop;
  logic [IW-1:0]     w_wr_idx, w_rd_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !i_push && !w_empty;
  // Entries below the top occupy r_mem[0 .. count-2].
  assign w_wr_idx  = IW'(r_count - CW'(1));
  assign w_rd_idx  = IW'(r_count - CW'(2));

  always_ff @(posedge i_clock) begin
    if (w_do_push && !w_empty) r_mem[w_wr_idx] <= r_top;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_top   <= i_push_data;
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_top   <= r_mem[w_rd_idx];
      r_count <= r_count - CW'(1);
    end
  end

  assign o_top   = r_top;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
endmodule

// File: rtl/loop_sequencer.sv
// Branch/loop sequencer: zero-latency PC source and squash decisions for CBF/CBB
// using a hardware loop stack and a nested forward-skip counter.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16,
  parameter int NEST_W = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       instr_valid,
  input  op_code_t                   instr,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       acc_zero,
  output logic                       squash,
  output logic                       pc_write,
  output pc_src_t                    pc_src,
  output logic [ADDR_W-1:0]          pc_target,
  output seq_state_t                 seq_state,
  output logic [$clog2(DEPTH+1)-1:0] loop_depth,
  output fault_t                     fault_code
);
  seq_state_t        r_state, w_state_nx;
  fault_t            r_fault, w_fault_nx;
  logic [NEST_W-1:0] r_nest, w_nest_nx;
  logic              w_push, w_pop, w_full, w_empty;
  logic [ADDR_W-1:0] w_top;

  loop_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_stack (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (pc),
    .o_top       (w_top),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (loop_depth)
  );

  always_comb begin
    w_state_nx = r_state;
    w_fault_nx = r_fault;
    w_nest_nx  = r_nest;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    squash     = 1'b1;
    pc_write   = 1'b0;
    pc_src     = PC_INCREMENTED;
    pc_target  = '0;
    if (!reset_n) begin
      squash = 1'b0;
    end else if (instr_valid) begin
      case (r_state)
        SEQ_RUN: begin
          case (instr)
            OP_CBF: begin
              if (acc_zero) begin
                pc_write   = 1'b1;
                w_state_nx = SEQ_SKIP;
                w_nest_nx  = NEST_W'(1);
              end else if (w_full) begin
                w_state_nx = SEQ_FAULT;
                w_fault_nx = FLT_OVERFLOW;
              end else begin
                pc_write = 1'b1;
                w_push   = 1'b1;
              end
            end
            OP_CBB: begin
              if (w_empty) begin
                w_state_nx = SEQ_FAULT;
                w_fault_nx = FLT_UNDERFLOW;
              end else if (acc_zero) begin
                pc_write = 1'b1;
                w_pop    = 1'b1;
              end else begin
                pc_write  = 1'b1;
                pc_src    = PC_LOOP_TARGET;
                pc_target = w_top + ADDR_W'(1);
              end
            end
            default: begin
              squash   = 1'b0;
              pc_write = 1'b1;
            end
          endcase
        end
        SEQ_SKIP: begin
          // Skipped code only tracks bracket nesting; the stack is never touched.
          pc_write = 1'b1;
          if (instr == OP_CBF) begin
            if (r_nest == {NEST_W{1'b1}}) begin
              pc_write   = 1'b0;
              w_state_nx = SEQ_FAULT;
              w_fault_nx = FLT_NEST;
            end else begin
              w_nest_nx = r_nest + NEST_W'(1);
            end
          end else if (instr == OP_CBB) begin
            w_nest_nx = r_nest - NEST_W'(1);
            if (r_nest == NEST_W'(1)) w_state_nx = SEQ_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEQ_RUN;
      r_fault <= FLT_NONE;
      r_nest  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_fault <= w_fault_nx;
      r_nest  <= w_nest_nx;
    end
  end

  assign seq_state  = r_state;
  assign fault_code = r_fault;
endmodule

// File: tb/tb_loop_sequencer.sv
// Table-driven bench for loop_sequencer (DEPTH=4) with a scoreboard queue of
// expected per-cycle outputs.
module tb_loop_sequencer;
  import loop_sequencer_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  op_code_t    instr;
  logic [15:0] pc;
  logic        acc_zero;
  logic        squash;
  logic        pc_write;
  pc_src_t     pc_src;
  logic [15:0] pc_target;
  seq_state_t  seq_state;
  logic [2:0]  loop_depth;
  fault_t      fault_code;

  loop_sequencer #(.ADDR_W(16), .DEPTH(4), .NEST_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .acc_zero    (acc_zero),
    .squash      (squash),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .seq_state   (seq_state),
    .loop_depth  (loop_depth),
    .fault_code  (fault_code)
  );

  typedef struct {
    logic        v;
    op_code_t    op;
    logic [15:0] pc;
    logic        az;
    logic        sq;
    logic        pw;
    pc_src_t     src;
    logic [15:0] tgt;
    seq_state_t  st;
    logic [2:0]  dep;
    fault_t      flt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec_no = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic v, op_code_t op, logic [15:0] p, logic az,
                              logic sq, logic pw, pc_src_t src, logic [15:0] tgt,
                              seq_state_t st, int dep, fault_t flt);
    vec_t e;
    e.v = v; e.op = op; e.pc = p; e.az = az;
    e.sq = sq; e.pw = pw; e.src = src; e.tgt = tgt;
    e.st = st; e.dep = 3'(dep); e.flt = flt;
    return e;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Called at posedge+1: drive, settle, compare against scoreboard, advance.
  task automatic apply(input vec_t e);
    vec_t x;
    instr_valid = e.v;
    instr       = e.op;
    pc          = e.pc;
    acc_zero    = e.az;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard [vec %0d]: got empty queue, expected entry", vec_no);
    end else begin
      x = sb.pop_front();
      check("squash",     vec_no, 32'(squash),     32'(x.sq));
      check("pc_write",   vec_no, 32'(pc_write),   32'(x.pw));
      check("pc_src",     vec_no, 32'(pc_src),     32'(x.src));
      if (x.src == PC_LOOP_TARGET)
        check("pc_target", vec_no, 32'(pc_target), 32'(x.tgt));
      check("seq_state",  vec_no, 32'(seq_state),  32'(x.st));
      check("loop_depth", vec_no, 32'(loop_depth), 32'(x.dep));
      check("fault_code", vec_no, 32'(fault_code), 32'(x.flt));
    end
    vec_no++;
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; asserts reset between edges, ends at posedge+1.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_squash"},     vec_no, 32'(squash),     32'(0));
    check({tag, "_pc_write"},   vec_no, 32'(pc_write),   32'(0));
    check({tag, "_pc_src"},     vec_no, 32'(pc_src),     32'(PC_INCREMENTED));
    check({tag, "_pc_target"},  vec_no, 32'(pc_target),  32'(0));
    check({tag, "_seq_state"},  vec_no, 32'(seq_state),  32'(SEQ_RUN));
    check({tag, "_loop_depth"}, vec_no, 32'(loop_depth), 32'(0));
    check({tag, "_fault_code"}, vec_no, 32'(fault_code), 32'(FLT_NONE));
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b1;
    instr       = OP_CBB;
    pc          = 16'h0000;
    acc_zero    = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Loop iterate/exit, nested skip with valid gating, wrap target, underflow.
    tbl.push_back(mk(1, OP_INC, 16'h0000, 0, 0, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBF, 16'h0010, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0011, 0, 0, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0020, 0, 1, 1, PC_LOOP_TARGET, 16'h0011, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0011, 1, 0, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0020, 1, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0021, 0, 0, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBF, 16'h0030, 1, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBF, 16'h0031, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_SKIP, 0, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0032, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_SKIP, 0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0033, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_SKIP, 0, FLT_NONE));
    tbl.push_back(mk(0, OP_CBB, 16'h0034, 0, 1, 0, PC_INCREMENTED, 16'h0000, SEQ_SKIP, 0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0034, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_SKIP, 0, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0035, 0, 0, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBF, 16'hFFFF, 0, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0040, 0, 1, 1, PC_LOOP_TARGET, 16'h0000, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0040, 1, 1, 1, PC_INCREMENTED, 16'h0000, SEQ_RUN,  1, FLT_NONE));
    tbl.push_back(mk(0, OP_INC, 16'h0041, 0, 1, 0, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_CBB, 16'h0050, 0, 1, 0, PC_INCREMENTED, 16'h0000, SEQ_RUN,  0, FLT_NONE));
    tbl.push_back(mk(1, OP_INC, 16'h0051, 0, 1, 0, PC_INCREMENTED, 16'h0000, SEQ_FAULT, 0, FLT_UNDERFLOW));
    tbl.push_back(mk(1, OP_CBF, 16'h0052, 0, 1, 0, PC_INCREMENTED, 16'h0000, SEQ_FAULT, 0, FLT_UNDERFLOW));
    foreach (tbl[i]) apply(tbl[i]);

    // Overflow: four pushes fill DEPTH=4, the fifth faults.
    do_reset();
    for (int i = 0; i < 4; i++)
      apply(mk(1, OP_CBF, 16'h0100 + 16'(i), 0, 1, 1, PC_INCREMENTED, 16'h0, SEQ_RUN, i, FLT_NONE));
    apply(mk(1, OP_CBF, 16'h0104, 0, 1, 0, PC_INCREMENTED, 16'h0, SEQ_RUN,   4, FLT_NONE));
    apply(mk(1, OP_INC, 16'h0105, 0, 1, 0, PC_INCREMENTED, 16'h0, SEQ_FAULT, 4, FLT_OVERFLOW));
    apply(mk(1, OP_CBB, 16'h0106, 1, 1, 0, PC_INCREMENTED, 16'h0, SEQ_FAULT, 4, FLT_OVERFLOW));

    // Reset mid-operation: depth 3, skip nest 2, reset between edges.
    do_reset();
    for (int i = 0; i < 3; i++)
      apply(mk(1, OP_CBF, 16'h0200 + 16'(i), 0, 1, 1, PC_INCREMENTED, 16'h0, SEQ_RUN, i, FLT_NONE));
    apply(mk(1, OP_CBF, 16'h0203, 1, 1, 1, PC_INCREMENTED, 16'h0, SEQ_RUN,  3, FLT_NONE));
    apply(mk(1, OP_CBF, 16'h0204, 0, 1, 1, PC_INCREMENTED, 16'h0, SEQ_SKIP, 3, FLT_NONE));
    apply(mk(1, OP_INC, 16'h0205, 0, 1, 1, PC_INCREMENTED, 16'h0, SEQ_SKIP, 3, FLT_NONE));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    apply(mk(1, OP_INC, 16'h0206, 0, 0, 1, PC_INCREMENTED, 16'h0, SEQ_RUN, 0, FLT_NONE));

    // Skip nesting limit: reach nest 255, one more CBF faults.
    do_reset();
    apply(mk(1, OP_CBF, 16'h0300, 1, 1, 1, PC_INCREMENTED, 16'h0, SEQ_RUN, 0, FLT_NONE));
    for (int i = 1; i < 255; i++)
      apply(mk(1, OP_CBF, 16'h0300 + 16'(i), 0, 1, 1, PC_INCREMENTED, 16'h0, SEQ_SKIP, 0, FLT_NONE));
    apply(mk(1, OP_CBF, 16'h0400, 0, 1, 0, PC_INCREMENTED, 16'h0, SEQ_SKIP,  0, FLT_NONE));
    apply(mk(1, OP_CBB, 16'h0401, 0, 1, 0, PC_INCREMENTED, 16'h0, SEQ_FAULT, 0, FLT_NEST));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
